// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: add/sub/logic/invert/shift with carry, zero, negative and
// overflow flags, behind a single valid-qualified pipeline stage.

package alu_8bit_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [7:0] result;
      logic       carry;
      logic       zero;
      logic       negative;
      logic       overflow;
   } alu_out_t;

endpackage

module alu_8bit
   import alu_8bit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   output logic [7:0] result,
   output logic       carry,
   output logic       zero,
   output logic       negative,
   output logic       overflow,
   output logic       out_valid
);

   alu_out_t   next_out;
   alu_out_t   out_q;
   logic       out_valid_q;
   logic [8:0] sum9;
   logic [8:0] diff9;

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
      next_out = '0;
      sum9     = {1'b0, a} + {1'b0, b};
      diff9    = {1'b0, a} - {1'b0, b};

      unique case (alu_op_e'(op))
         OP_ADD: begin
            next_out.result   = sum9[7:0];
            next_out.carry    = sum9[8];
            next_out.overflow = (a[7] == b[7]) && (sum9[7] != a[7]);
         end
         OP_SUB: begin
            // Bit 8 of the zero-extended difference is the borrow: set iff a < b unsigned.
            next_out.result   = diff9[7:0];
            next_out.carry    = diff9[8];
            next_out.overflow = (a[7] != b[7]) && (diff9[7] != a[7]);
         end
         OP_AND: next_out.result = a & b;
         OP_OR:  next_out.result = a | b;
         OP_XOR: next_out.result = a ^ b;
         OP_NOT: next_out.result = ~a;
         OP_SHL: begin
            next_out.result = {a[6:0], 1'b0};
            next_out.carry  = a[7];
         end
         OP_SHR: begin
            next_out.result = {1'b0, a[7:1]};
            next_out.carry  = a[0];
         end
      endcase

      next_out.zero     = (next_out.result == 8'h00);
      next_out.negative = next_out.result[7];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: reset clears every output bit, including zero, rather than deriving it from result.
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all state samples pre-edge values.
         out_valid_q <= in_valid;
         if (in_valid) begin
            out_q <= next_out;
         end
      end
   end

   assign result    = out_q.result;
   assign carry     = out_q.carry;
   assign zero      = out_q.zero;
   assign negative  = out_q.negative;
   assign overflow  = out_q.overflow;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed ops push expectations, a negedge monitor
// pops and compares whenever out_valid is high.

module tb_alu_8bit;
   import alu_8bit_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic [7:0] result;
   logic       carry;
   logic       zero;
   logic       negative;
   logic       overflow;
   logic       out_valid;

   int n_compared = 0;
   int n_mismatch = 0;
   alu_out_t exp_q[$];

   alu_8bit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .op       (op),
      .result   (result),
      .carry    (carry),
      .zero     (zero),
      .negative (negative),
      .overflow (overflow),
      .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatch++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [11:0] dut_out();
      return {result, carry, zero, negative, overflow};
   endfunction

   // Drive one op just after a rising edge and record its expected response.
   task automatic issue(input alu_op_e op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic [7:0] r, input logic c, input logic z,
                        input logic n, input logic v);
      alu_out_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = a_v;
      b        = b_v;
      op       = op_v;
      e.result   = r;
      e.carry    = c;
      e.zero     = z;
      e.negative = n;
      e.overflow = v;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
      op       = 3'($urandom);
   endtask

   // Monitor: compare each valid output against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            alu_out_t e;
            e = exp_q.pop_front();
            check($sformatf("op_out{res,c,z,n,v} #%0d", n_compared), 32'(dut_out()), 32'(e));
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      alu_out_t hold_v;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      op       = 3'b000;

      #3;
      check("reset_outputs", 32'({dut_out(), out_valid}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic ops, A=0x0A B=0x03, back to back.
      issue(OP_ADD, 8'h0A, 8'h03, 8'h0D, 0, 0, 0, 0);
      issue(OP_SUB, 8'h0A, 8'h03, 8'h07, 0, 0, 0, 0);
      issue(OP_AND, 8'h0A, 8'h03, 8'h02, 0, 0, 0, 0);
      issue(OP_OR,  8'h0A, 8'h03, 8'h0B, 0, 0, 0, 0);
      issue(OP_XOR, 8'h0A, 8'h03, 8'h09, 0, 0, 0, 0);
      issue(OP_NOT, 8'h0A, 8'h00, 8'hF5, 0, 0, 1, 0);
      issue(OP_SHL, 8'h0A, 8'h03, 8'h14, 0, 0, 0, 0);
      issue(OP_SHR, 8'h0A, 8'h03, 8'h05, 0, 0, 0, 0);
      // Carry / zero boundaries.
      issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
      issue(OP_SUB, 8'h03, 8'h0A, 8'hF9, 1, 0, 1, 0);
      issue(OP_SUB, 8'h55, 8'h55, 8'h00, 0, 1, 0, 0);
      // Shift-out (b is ignored, so give it noise).
      issue(OP_SHL, 8'h80, 8'h5A, 8'h00, 1, 1, 0, 0);
      issue(OP_SHR, 8'h01, 8'hA5, 8'h00, 1, 1, 0, 0);
      issue(OP_SHR, 8'h81, 8'hFF, 8'h40, 1, 0, 0, 0);
      // Signed overflow.
      issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
      issue(OP_SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1);
      issue(OP_AND, 8'hFF, 8'h80, 8'h80, 0, 0, 1, 0);
      issue(OP_ADD, 8'h80, 8'h80, 8'h00, 1, 1, 0, 1);
      issue(OP_SUB, 8'h7F, 8'hFF, 8'h80, 1, 0, 1, 1);
      idle();

      // Hold: one op then idle cycles with changing inputs.
      issue(OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
      hold_v = exp_q[exp_q.size()-1];
      idle();
      for (int i = 0; i < 3; i++) begin
         idle();
         check($sformatf("hold_out_valid_%0d", i), 32'(out_valid), 32'd0);
         check($sformatf("hold_out{res,c,z,n,v}_%0d", i), 32'(dut_out()), 32'(hold_v));
      end

      // Asynchronous reset mid-stream, between edges, with an op in flight.
      issue(OP_XOR, 8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = 8'h10;
      b        = 8'h01;
      op       = OP_SUB;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midstream_reset_outputs", 32'({dut_out(), out_valid}), 32'd0);
      #1;
      rst_n    = 1'b1;
      a        = 8'h01;
      b        = 8'h01;
      op       = OP_ADD;
      in_valid = 1'b1;
      begin
         alu_out_t e;
         e = '{result: 8'h02, carry: 1'b0, zero: 1'b0, negative: 1'b0, overflow: 1'b0};
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("first_op_after_reset_valid", 32'(out_valid), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
